bcd_counter_nd: RTL and testbench

//   Parametrised multi-digit BCD up/down counter; next generation of the team's

---
 rtl/bcd_counter_nd.sv | 98 +++++++++
 tb/tb_bcd_counter_nd.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_nd.sv
// bcd_counter_nd: parametrised multi-digit BCD up/down counter with
// parallel load, wrap/saturate mode and a cascadable wrap pulse.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   en        count enable, one step per clock
//   up_dn     1 = count up, 0 = count down
//   load      parallel load request (priority over en)
//   load_val  BCD value to load, digit i = bits [4i+3:4i]
//   count     current BCD value, digit 0 least significant
//   wrap      one-cycle pulse when count wrapped max->0 or 0->max
//   at_max    count is all nines
//   at_min    count is zero
//   load_err  one-cycle pulse when a load held a non-BCD digit
module bcd_counter_nd #(
   parameter int DIGITS = 4,
   parameter bit WRAP   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap,
   output logic                  at_max,
   output logic                  at_min,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] step_val;
   logic         edge_hit;
   logic         lv_ok;

   // Ripple carry/borrow: edge_hit survives the loop only when every
   // digit was 9 (up) or 0 (down), i.e. the step crosses max/min.
   always_comb begin
      step_val = count;
      edge_hit = 1'b1;
      lv_ok    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9)
            lv_ok = 1'b0;
         if (edge_hit) begin
            if (up_dn) begin
               if (count[4*i +: 4] == 4'd9) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                  edge_hit = 1'b0;
               end
            end else begin
               if (count[4*i +: 4] == 4'd0) begin
                  step_val[4*i +: 4] = 4'd9;
               end else begin
                  step_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                  edge_hit = 1'b0;
               end
            end
         end
      end
   end

   assign at_max = (count == {DIGITS{4'h9}});
   assign at_min = (count == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            if (lv_ok)
               count <= load_val;
            else
               load_err <= 1'b1;
         end else if (en) begin
            // Crossing max/min: wrap mode takes the rolled-over value,
            // saturate mode simply holds.
            if (edge_hit) begin
               if (WRAP) begin
                  count <= step_val;
                  wrap  <= 1'b1;
               end
            end else begin
               count <= step_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Bench for bcd_counter_nd: four instances (4/wrap, 4/sat, 1/wrap,
// 8/sat) on shared inputs, checked against a decimal reference model.
module tb_bcd_counter_nd;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        up_dn = 1'b0;
   logic        load = 1'b0;
   logic [31:0] lv = '0;

   logic [15:0] c0, c1;
   logic [3:0]  c2;
   logic [31:0] c3;
   logic [3:0]  wr, le, amx, amn;

   always #5 clk = ~clk;

   bcd_counter_nd #(.DIGITS(4), .WRAP(1'b1)) u0 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(lv[15:0]), .count(c0), .wrap(wr[0]), .at_max(amx[0]),
      .at_min(amn[0]), .load_err(le[0]));
   bcd_counter_nd #(.DIGITS(4), .WRAP(1'b0)) u1 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(lv[15:0]), .count(c1), .wrap(wr[1]), .at_max(amx[1]),
      .at_min(amn[1]), .load_err(le[1]));
   bcd_counter_nd #(.DIGITS(1), .WRAP(1'b1)) u2 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(lv[3:0]), .count(c2), .wrap(wr[2]), .at_max(amx[2]),
      .at_min(amn[2]), .load_err(le[2]));
   bcd_counter_nd #(.DIGITS(8), .WRAP(1'b0)) u3 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(lv), .count(c3), .wrap(wr[3]), .at_max(amx[3]),
      .at_min(amn[3]), .load_err(le[3]));

   int dg [4] = '{4, 4, 1, 8};
   bit wm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   int val [4] = '{0, 0, 0, 0};

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct packed {
      logic [3:0][31:0] cnt;
      logic [3:0]       wr;
      logic [3:0]       le;
      logic [3:0]       mx;
      logic [3:0]       mn;
   } sb_t;
   sb_t q[$];

   typedef struct {
      logic        e;
      logic        u;
      logic        l;
      logic [15:0] v;
      logic [15:0] c;
      logic        w;
      logic        le;
   } vec_t;
   vec_t tbl[20];

   function automatic vec_t mk(logic e, logic u, logic l, logic [15:0] v,
                               logic [15:0] c, logic w, logic lerr);
      vec_t r;
      r.e = e; r.u = u; r.l = l; r.v = v; r.c = c; r.w = w; r.le = lerr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t",
                    name, act, exp, $time);
   endtask

   function automatic int pow10(int d);
      int r = 1;
      for (int i = 0; i < d; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(int v, int d);
      logic [31:0] r = '0;
      int x = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] act_cnt(int k);
      case (k)
         0: return {16'h0, c0};
         1: return {16'h0, c1};
         2: return {28'h0, c2};
         default: return c3;
      endcase
   endfunction

   function automatic logic digits_ok(logic [31:0] c, int d);
      logic ok = 1'b1;
      for (int i = 0; i < d; i++)
         if (c[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   // Decimal reference model: one step for every instance, result queued.
   task automatic model(input logic e, input logic u, input logic l,
                        input logic [31:0] v);
      sb_t s;
      s = '0;
      for (int k = 0; k < 4; k++) begin
         int mx = pow10(dg[k]) - 1;
         if (l) begin
            int acc = 0;
            int pw = 1;
            bit ok = 1'b1;
            for (int i = 0; i < dg[k]; i++) begin
               int d = int'(v[4*i +: 4]);
               if (d > 9) ok = 1'b0;
               acc = acc + d * pw;
               pw = pw * 10;
            end
            if (ok) val[k] = acc;
            else s.le[k] = 1'b1;
         end else if (e) begin
            if (u) begin
               if (val[k] == mx) begin
                  if (wm[k]) begin val[k] = 0; s.wr[k] = 1'b1; end
               end else val[k] = val[k] + 1;
            end else begin
               if (val[k] == 0) begin
                  if (wm[k]) begin val[k] = mx; s.wr[k] = 1'b1; end
               end else val[k] = val[k] - 1;
            end
         end
         s.cnt[k] = to_bcd(val[k], dg[k]);
         s.mx[k] = (val[k] == mx);
         s.mn[k] = (val[k] == 0);
      end
      q.push_back(s);
   endtask

   task automatic compare_all();
      sb_t s;
      if (q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         return;
      end
      s = q.pop_front();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("count[%0d]", k), act_cnt(k), s.cnt[k]);
         chk($sformatf("wrap[%0d]", k), {31'h0, wr[k]}, {31'h0, s.wr[k]});
         chk($sformatf("load_err[%0d]", k), {31'h0, le[k]}, {31'h0, s.le[k]});
         chk($sformatf("at_max[%0d]", k), {31'h0, amx[k]}, {31'h0, s.mx[k]});
         chk($sformatf("at_min[%0d]", k), {31'h0, amn[k]}, {31'h0, s.mn[k]});
         chk($sformatf("digits[%0d]", k),
             {31'h0, digits_ok(act_cnt(k), dg[k])}, 32'd1);
      end
   endtask

   task automatic step(input logic e, input logic u, input logic l,
                       input logic [31:0] v);
      @(negedge clk);
      en = e; up_dn = u; load = l; lv = v;
      model(e, u, l, v);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic reset_check(input string name);
      for (int k = 0; k < 4; k++) begin
         chk({name, "_cnt"}, act_cnt(k), 32'd0);
         chk({name, "_min"}, {31'h0, amn[k]}, 32'd1);
         chk({name, "_max"}, {31'h0, amx[k]}, 32'd0);
         chk({name, "_wrap"}, {31'h0, wr[k]}, 32'd0);
         chk({name, "_lerr"}, {31'h0, le[k]}, 32'd0);
      end
   endtask

   initial begin
      tbl[0]  = mk(1, 1, 1, 16'h0999, 16'h0999, 0, 0);
      tbl[1]  = mk(1, 1, 0, 16'h0000, 16'h1000, 0, 0);
      tbl[2]  = mk(0, 1, 1, 16'h9998, 16'h9998, 0, 0);
      tbl[3]  = mk(1, 1, 0, 16'h0000, 16'h9999, 0, 0);
      tbl[4]  = mk(1, 1, 0, 16'h0000, 16'h0000, 1, 0);
      tbl[5]  = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0);
      tbl[6]  = mk(0, 0, 1, 16'h0001, 16'h0001, 0, 0);
      tbl[7]  = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0);
      tbl[8]  = mk(1, 0, 0, 16'h0000, 16'h9999, 1, 0);
      tbl[9]  = mk(0, 1, 1, 16'h12A4, 16'h9999, 0, 1);
      tbl[10] = mk(0, 1, 0, 16'h0000, 16'h9999, 0, 0);
      tbl[11] = mk(1, 1, 1, 16'h0042, 16'h0042, 0, 0);
      tbl[12] = mk(1, 1, 0, 16'h0000, 16'h0043, 0, 0);
      tbl[13] = mk(1, 0, 0, 16'h0000, 16'h0042, 0, 0);
      tbl[14] = mk(1, 0, 0, 16'h0000, 16'h0041, 0, 0);
      tbl[15] = mk(1, 1, 1, 16'h9999, 16'h9999, 0, 0);
      tbl[16] = mk(1, 1, 0, 16'h0000, 16'h0000, 1, 0);
      tbl[17] = mk(1, 1, 0, 16'h0000, 16'h0001, 0, 0);
      tbl[18] = mk(1, 1, 1, 16'hF000, 16'h0001, 0, 1);
      tbl[19] = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0);

      #12;
      reset_check("por");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].e, tbl[i].u, tbl[i].l, {16'h0, tbl[i].v});
         chk($sformatf("tbl%0d_count", i), {16'h0, c0}, {16'h0, tbl[i].c});
         chk($sformatf("tbl%0d_wrap", i), {31'h0, wr[0]}, {31'h0, tbl[i].w});
         chk($sformatf("tbl%0d_lerr", i), {31'h0, le[0]}, {31'h0, tbl[i].le});
      end

      // Saturating 4-digit instance: hold at 0000 going down.
      step(0, 0, 1, 32'h0001);
      step(1, 0, 0, 32'h0);
      chk("sat_dn_0", {16'h0, c1}, 32'h0);
      step(1, 0, 0, 32'h0);
      chk("sat_dn_hold", {16'h0, c1}, 32'h0);
      chk("sat_dn_wrap", {31'h0, wr[1]}, 32'd0);
      chk("sat_dn_min", {31'h0, amn[1]}, 32'd1);

      // Saturating: five up steps at 9999 never move or pulse wrap.
      step(0, 1, 1, 32'h9999);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0, 32'h0);
         chk("sat_up_hold", {16'h0, c1}, 32'h9999);
         chk("sat_up_wrap", {31'h0, wr[1]}, 32'd0);
         chk("sat_up_max", {31'h0, amx[1]}, 32'd1);
      end

      // Asynchronous reset mid-count at 0456.
      step(0, 1, 1, 32'h0456);
      step(1, 1, 0, 32'h0);
      chk("pre_rst", {16'h0, c0}, 32'h0457);
      @(negedge clk);
      en = 1'b0; load = 1'b0;
      #2 reset = 1'b0;
      #1 reset_check("async_rst");
      for (int k = 0; k < 4; k++) val[k] = 0;
      @(posedge clk);
      #1 reset_check("rst_hold");
      @(negedge clk);
      reset = 1'b1;

      // Random traffic against the model.
      for (int n = 0; n < 10000; n++) begin
         logic [31:0] v;
         logic l, e, u;
         v = '0;
         for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0)
            v[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 5) == 0)
            v = ($urandom_range(0, 1) == 1) ? 32'h9999_9999 : 32'h0;
         l = ($urandom_range(0, 7) == 0);
         e = ($urandom_range(0, 3) != 0);
         u = ($urandom_range(0, 1) == 1);
         step(e, u, l, v);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
